// File: rtl/convertor_rns_to_int_seq_64.sv
// -----------------------------------------------------------------------------
// convertor_rns_to_int_seq_64
//
// Sequential RNS -> signed 64-bit integer converter (Chinese Remainder Theorem).
// One accepted word passes through four phases:
//   ACCUM  : acc += A_i * r_i, one residue per cycle (9 cycles)
//   REDUCE : restoring remainder acc mod M, one shifted modulus per cycle (13)
//   SIGN   : map [M/2, M) onto negative numbers by adding (2^64 - M) mod 2^64
//   HOLD   : present the result until the consumer takes it
// The accept edge opens a 24-cycle window: the result is visible in the 24th
// cycle, and a new word can be taken one cycle after the result retires.
//
// Optional feature: define RNS_RANGE_CHECK_EN to build the residue range
// comparators behind range_err. Without it range_err is tied low.
//
// Base: 2, 255, 253, 251, 247, 241, 239, 233, 229 (pairwise coprime, M > 2^64).
// The constants below are only defined when a shared constants file has not
// already provided them. A_i = (M/B_i) * ((M/B_i)^-1 mod B_i), which is
// already below M, so no further reduction is needed.
// -----------------------------------------------------------------------------

`ifndef B0
`define B0 2
`endif
`ifndef B1
`define B1 255
`endif
`ifndef B2
`define B2 253
`endif
`ifndef B3
`define B3 251
`endif
`ifndef B4
`define B4 247
`endif
`ifndef B5
`define B5 241
`endif
`ifndef B6
`define B6 239
`endif
`ifndef B7
`define B7 233
`endif
`ifndef B8
`define B8 229
`endif

`ifndef MAX_NUM_64
`define MAX_NUM_64 (65'd2*65'd255*65'd253*65'd251*65'd247*65'd241*65'd239*65'd233*65'd229)
`endif
`ifndef RNS_MIDDLE_POINT_64
`define RNS_MIDDLE_POINT_64 ((`MAX_NUM_64) >> 1)
`endif
`ifndef INT_RNS_DELTA_64
`define INT_RNS_DELTA_64 (64'(65'd0 - (`MAX_NUM_64)))
`endif

`ifndef A0
`define A0 (65'd255*65'd253*65'd251*65'd247*65'd241*65'd239*65'd233*65'd229*65'd1)
`endif
`ifndef A1
`define A1 (65'd2*65'd253*65'd251*65'd247*65'd241*65'd239*65'd233*65'd229*65'd121)
`endif
`ifndef A2
`define A2 (65'd2*65'd255*65'd251*65'd247*65'd241*65'd239*65'd233*65'd229*65'd52)
`endif
`ifndef A3
`define A3 (65'd2*65'd255*65'd253*65'd247*65'd241*65'd239*65'd233*65'd229*65'd176)
`endif
`ifndef A4
`define A4 (65'd2*65'd255*65'd253*65'd251*65'd241*65'd239*65'd233*65'd229*65'd230)
`endif
`ifndef A5
`define A5 (65'd2*65'd255*65'd253*65'd251*65'd247*65'd239*65'd233*65'd229*65'd38)
`endif
`ifndef A6
`define A6 (65'd2*65'd255*65'd253*65'd251*65'd247*65'd241*65'd233*65'd229*65'd199)
`endif
`ifndef A7
`define A7 (65'd2*65'd255*65'd253*65'd251*65'd247*65'd241*65'd239*65'd229*65'd48)
`endif
`ifndef A8
`define A8 (65'd2*65'd255*65'd253*65'd251*65'd247*65'd241*65'd239*65'd233*65'd227)
`endif

module convertor_rns_to_int_seq_64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [64:0] rns,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] int_number,
  output logic        range_err
);

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    REDUCE,
    SIGN,
    HOLD
  } state_t;

  // Dynamic range M, the signed split point M/2 and the negative offset.
  localparam logic [76:0] LP_MAX   = 77'(`MAX_NUM_64);
  localparam logic [76:0] LP_MID   = 77'(`RNS_MIDDLE_POINT_64);
  localparam logic [63:0] LP_DELTA = 64'(`INT_RNS_DELTA_64);

  localparam logic [3:0]  LP_LAST_IDX = 4'd8;
  localparam logic [3:0]  LP_TOP_K    = 4'd12;

  state_t      r_state;
  state_t      w_next_state;

  logic [64:0] r_rns;
  logic [76:0] r_acc;
  logic [3:0]  r_idx;
  logic [3:0]  r_k;
  logic        r_out_valid;
  logic [63:0] r_int_number;

  logic        w_accept;
  logic        w_retire;
  logic [64:0] w_weight;
  logic [7:0]  w_residue;
  logic [72:0] w_term;
  logic [76:0] w_shifted_mod;
  logic        w_acc_ge_mod;
  logic        w_negative;

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = r_out_valid;
  assign int_number = r_int_number;

  assign w_accept = in_ready && in_valid;
  assign w_retire = r_out_valid && out_ready;

  // Select the CRT weight and residue for the term handled this ACCUM cycle.
  always_comb begin
    w_weight  = '0;
    w_residue = '0;
    case (r_idx)
      4'd0: begin w_weight = 65'(`A0); w_residue = {7'd0, r_rns[0]}; end
      4'd1: begin w_weight = 65'(`A1); w_residue = r_rns[8:1];       end
      4'd2: begin w_weight = 65'(`A2); w_residue = r_rns[16:9];      end
      4'd3: begin w_weight = 65'(`A3); w_residue = r_rns[24:17];     end
      4'd4: begin w_weight = 65'(`A4); w_residue = r_rns[32:25];     end
      4'd5: begin w_weight = 65'(`A5); w_residue = r_rns[40:33];     end
      4'd6: begin w_weight = 65'(`A6); w_residue = r_rns[48:41];     end
      4'd7: begin w_weight = 65'(`A7); w_residue = r_rns[56:49];     end
      4'd8: begin w_weight = 65'(`A8); w_residue = r_rns[64:57];     end
      default: begin
        w_weight  = '0;
        w_residue = '0;
      end
    endcase
  end

  // Term product and the comparisons used by REDUCE and SIGN.
  assign w_term        = {8'd0, w_weight} * {65'd0, w_residue};
  assign w_shifted_mod = LP_MAX << r_k;
  assign w_acc_ge_mod  = (r_acc >= w_shifted_mod);
  assign w_negative    = (r_acc >= LP_MID);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values;
    // blocking assignments here would make results depend on block order.
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: the default assignment first keeps every path driven, so no
    // latch is inferred when a branch below leaves the state unchanged.
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept)               w_next_state = ACCUM;
      ACCUM:   if (r_idx == LP_LAST_IDX)   w_next_state = REDUCE;
      REDUCE:  if (r_k == 4'd0)            w_next_state = SIGN;
      SIGN:                                w_next_state = HOLD;
      HOLD:    if (w_retire)               w_next_state = IDLE;
      default:                             w_next_state = IDLE;
    endcase
  end

  // Input word capture on the accept edge.
  always_ff @(posedge clk) begin
    // NOTE: r_rns is pure data, always written at accept before it is read,
    // so it carries no reset; everything that steers control is reset.
    if (w_accept) begin
      r_rns <= rns;
    end
  end

  // Accumulate, reduce, sign-map and hold the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc        <= '0;
      r_idx        <= '0;
      r_k          <= '0;
      r_out_valid  <= 1'b0;
      r_int_number <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc <= '0;
            r_idx <= '0;
          end
        end
        ACCUM: begin
          r_acc <= r_acc + {4'd0, w_term};
          r_idx <= r_idx + 4'd1;
          if (r_idx == LP_LAST_IDX) begin
            r_k <= LP_TOP_K;
          end
        end
        REDUCE: begin
          if (w_acc_ge_mod) begin
            r_acc <= r_acc - w_shifted_mod;
          end
          if (r_k != 4'd0) begin
            r_k <= r_k - 4'd1;
          end
        end
        SIGN: begin
          r_int_number <= w_negative ? (r_acc[63:0] + LP_DELTA) : r_acc[63:0];
          r_out_valid  <= 1'b1;
        end
        HOLD: begin
          if (w_retire) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef RNS_RANGE_CHECK_EN
  logic w_range_bad;
  logic r_range_pend;
  logic r_range_err;

  // Out-of-range residue detect on the incoming word; the 1-bit residue
  // mod 2 can never reach its modulus, so it needs no comparator.
  always_comb begin
    w_range_bad = (rns[8:1]   >= 8'(`B1)) |
                  (rns[16:9]  >= 8'(`B2)) |
                  (rns[24:17] >= 8'(`B3)) |
                  (rns[32:25] >= 8'(`B4)) |
                  (rns[40:33] >= 8'(`B5)) |
                  (rns[48:41] >= 8'(`B6)) |
                  (rns[56:49] >= 8'(`B7)) |
                  (rns[64:57] >= 8'(`B8));
  end

  // Latch the flag at accept and present it together with the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_range_pend <= 1'b0;
      r_range_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_range_pend <= w_range_bad;
        r_range_err  <= 1'b0;
      end
      if (r_state == SIGN) begin
        r_range_err <= r_range_pend;
      end
    end
  end

  assign range_err = r_range_err;
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_convertor_rns_to_int_seq_64.sv
// -----------------------------------------------------------------------------
// Testbench for convertor_rns_to_int_seq_64.
// A driver pushes the expected result of each accepted word into a queue; an
// independent monitor pops and compares whenever the DUT presents a result.
// Words are built by forward-encoding known integers into residues, so each
// expected value is the integer itself.
// -----------------------------------------------------------------------------

`ifndef B0
`define B0 2
`endif
`ifndef B1
`define B1 255
`endif
`ifndef B2
`define B2 253
`endif
`ifndef B3
`define B3 251
`endif
`ifndef B4
`define B4 247
`endif
`ifndef B5
`define B5 241
`endif
`ifndef B6
`define B6 239
`endif
`ifndef B7
`define B7 233
`endif
`ifndef B8
`define B8 229
`endif

module tb_convertor_rns_to_int_seq_64;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [64:0] rns;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] int_number;
  logic        range_err;

  typedef struct {
    logic [63:0] val;
    bit          chk_val;
    bit          rerr;
    int unsigned acc_cyc;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc;
  int          n_checks;
  int          n_fail;

  convertor_rns_to_int_seq_64 dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rns        (rns),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .int_number (int_number),
    .range_err  (range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Forward RNS encoding of a signed 64-bit integer.
  function automatic logic [64:0] encode(input logic [63:0] v);
    logic [64:0] w;
    longint      sv;
    longint      r;
    int          m [9];
    m  = '{`B0, `B1, `B2, `B3, `B4, `B5, `B6, `B7, `B8};
    w  = '0;
    sv = $signed(v);
    for (int i = 0; i < 9; i++) begin
      r = sv % longint'(m[i]);
      if (r < 0) r = r + longint'(m[i]);
      if (i == 0) w[0] = r[0];
      else        w[8*i -: 8] = r[7:0];
    end
    return w;
  endfunction

  // Offer one word, wait (bounded) for acceptance, record the expectation.
  task automatic send(input logic [64:0] word, input logic [63:0] val, input bit chk,
                      input bit rerr, input int junk_cycles, output int unsigned acc_cyc);
    int   waited;
    exp_t e;
    waited   = 0;
    acc_cyc  = 0;
    in_valid = 1'b1;
    rns      = word;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", waited);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    e.val     = val;
    e.chk_val = chk;
    e.rerr    = rerr;
    e.acc_cyc = cyc;
    acc_cyc   = cyc;
    sb_q.push_back(e);
    if (junk_cycles > 0) begin
      rns = ~word;
      repeat (junk_cycles) @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rns      = '0;
  endtask

  // Wait (bounded) until every expected result has been seen.
  task automatic drain();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    #1;
    check("drain_pending", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
  endtask

  // Monitor: compares every presented result with the queue head.
  initial begin : monitor
    bit prev_v;
    bit expect_idle;
    prev_v      = 1'b0;
    expect_idle = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v      = 1'b0;
        expect_idle = 1'b0;
      end else begin
        if (expect_idle) begin
          check("in_ready_after_retire", 64'(in_ready), 64'd1);
          check("out_valid_after_retire", 64'(out_valid), 64'd0);
          expect_idle = 1'b0;
        end
        if (out_valid) begin
          if (sb_q.size() == 0) begin
            check("unexpected_out_valid", 64'(out_valid), 64'd0);
          end else begin
            if (!prev_v) check("latency", 64'(cyc - sb_q[0].acc_cyc + 1), 64'd24);
            if (sb_q[0].chk_val) check("int_number", int_number, sb_q[0].val);
            check("range_err", 64'(range_err), 64'(sb_q[0].rerr));
            check("in_ready_while_holding", 64'(in_ready), 64'd0);
            if (out_ready) begin
              void'(sb_q.pop_front());
              expect_idle = 1'b1;
            end
          end
        end
        prev_v = out_valid;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [63:0] vals [9];
    int unsigned acc_now;
    int unsigned acc_prev;
    int          waited;
    bit          seen;
    logic [64:0] word;
    bit          rerr_exp;

    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    rns       = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_int_number", int_number, 64'd0);
    check("reset_range_err", 64'(range_err), 64'd0);
    @(posedge clk);
    #1;

    // Directed values, issued back to back; one is offered with in_valid
    // held high and garbage on rns while the converter is busy.
    vals = '{64'd0, 64'd100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd5,
             64'hFFFF_FFFF_FFFF_FF9C, 64'h7FFF_FFFF_FFFF_FFFF,
             64'h8000_0000_0000_0000, 64'h0123_4567_89AB_CDEF};
    acc_prev = 0;
    for (int i = 0; i < 9; i++) begin
      send(encode(vals[i]), vals[i], 1'b1, 1'b0, (i == 3) ? 20 : 0, acc_now);
      if (i > 0) check("throughput", 64'(acc_now - acc_prev), 64'd25);
      acc_prev = acc_now;
    end
    drain();

    // Backpressure: consumer stalls 10 cycles after the result appears.
    out_ready = 1'b0;
    send(encode(64'hFFFF_FFFF_FFFF_CFC7), 64'hFFFF_FFFF_FFFF_CFC7, 1'b1, 1'b0, 0, acc_now);
    waited = 0;
    while (!out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("backpressure_out_valid_seen", 64'(out_valid), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Reset in the 12th REDUCE cycle discards the conversion.
    send(encode(64'd777), 64'd777, 1'b1, 1'b0, 0, acc_now);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", 64'(in_ready), 64'd1);
    check("post_reset_int_number", int_number, 64'd0);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("no_out_valid_after_reset", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    send(encode(64'd1), 64'd1, 1'b1, 1'b0, 0, acc_now);
    drain();

    // Range check: residue mod B1 equal to its modulus, then a clean word.
`ifdef RNS_RANGE_CHECK_EN
    rerr_exp = 1'b1;
`else
    rerr_exp = 1'b0;
`endif
    word      = encode(64'd7);
    word[8:1] = 8'(`B1);
    send(word, 64'd0, 1'b0, rerr_exp, 0, acc_now);
    send(encode(64'd42), 64'd42, 1'b1, 1'b0, 0, acc_now);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
